// File: rtl/gba_dump_command_parser_if.sv
// Byte stream, reader handshake and status bundle between the host link, the
// dump command parser and the cartridge reader.
interface gba_dump_command_parser_if;
    logic [7:0]  in_Data;
    logic        in_Valid;
    logic        dumpCompleted;
    logic [23:0] dumpStartAddress;
    logic [23:0] dumpEndAddress;
    logic        startDump;
    logic        busy;
    logic        cmd_error;

    modport master (
        output in_Data, in_Valid, dumpCompleted,
        input  dumpStartAddress, dumpEndAddress, startDump, busy, cmd_error
    );

    modport slave (
        input  in_Data, in_Valid, dumpCompleted,
        output dumpStartAddress, dumpEndAddress, startDump, busy, cmd_error
    );
endinterface

// File: rtl/gba_dump_command_parser.sv
// Parses 8-byte 'D' dump packets from the UART byte stream, validates them and
// launches the cartridge reader, tracking it until the dump completes.
module gba_dump_command_parser #(
    parameter logic [7:0]  CMD_DUMP       = 8'h44,
    parameter int unsigned TIMEOUT_CYCLES = 27000000
) (
    input logic                        clk,
    input logic                        rst,
    gba_dump_command_parser_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        CHECK,
        START,
        WAIT_LOW,
        WAIT_HIGH
    } state_e;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [47:0]      shadow_q;
    logic [47:0]      shadow_d;
    logic [7:0]       chk_q;
    logic [7:0]       chk_d;
    logic [7:0]       ck_q;
    logic [CNT_W-1:0] tmo_q;
    logic [23:0]      start_addr_q;
    logic [23:0]      end_addr_q;
    logic             start_dump_q;
    logic             busy_q;
    logic             cmd_error_q;
    logic             reject;

    assign shadow_d = {shadow_q[39:0], bus.in_Data};
    assign chk_d    = chk_q ^ bus.in_Data;
    assign reject   = (ck_q != chk_q) || (shadow_q[23:0] < shadow_q[47:24]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            shadow_q     <= '0;
            chk_q        <= '0;
            ck_q         <= '0;
            tmo_q        <= '0;
            start_addr_q <= '0;
            end_addr_q   <= '0;
            start_dump_q <= 1'b0;
            busy_q       <= 1'b0;
            cmd_error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults first make the status bits one-cycle
            // pulses; any later assignment in the same cycle overrides them.
            start_dump_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_Valid && bus.in_Data == CMD_DUMP) begin
                        idx_q   <= '0;
                        chk_q   <= '0;
                        tmo_q   <= '0;
                        state_q <= RX_ADDR;
                    end
                end
                RX_ADDR: begin
                    // A byte in the expiry cycle still counts and restarts the timer.
                    if (bus.in_Valid) begin
                        tmo_q <= '0;
                        if (idx_q == 3'd6) begin
                            ck_q    <= bus.in_Data;
                            state_q <= CHECK;
                        end else begin
                            shadow_q <= shadow_d;
                            chk_q    <= chk_d;
                            idx_q    <= idx_q + 3'd1;
                        end
                    end else if (tmo_q == CNT_LAST) begin
                        shadow_q    <= '0;
                        cmd_error_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end
                CHECK: begin
                    if (reject) begin
                        cmd_error_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        start_addr_q <= shadow_q[47:24];
                        end_addr_q   <= shadow_q[23:0];
                        busy_q       <= 1'b1;
                        start_dump_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    state_q <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!bus.dumpCompleted) begin
                        state_q <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (bus.dumpCompleted) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dumpStartAddress = start_addr_q;
    assign bus.dumpEndAddress   = end_addr_q;
    assign bus.startDump        = start_dump_q;
    assign bus.busy             = busy_q;
    assign bus.cmd_error        = cmd_error_q;
endmodule

// File: tb/tb_gba_dump_command_parser.sv
// Directed bench for the dump command parser: a packet table plus hand-written
// timeout, garbage, busy-drop and asynchronous-reset sequences.
module tb_gba_dump_command_parser;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   reader_cnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_start = 0;
    int   n_err = 0;
    int   n_both = 0;
    logic [23:0] exp_sa = '0;
    logic [23:0] exp_ea = '0;

    gba_dump_command_parser_if bus ();

    gba_dump_command_parser #(
        .CMD_DUMP       (8'h44),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reader model: leaves idle on startDump, busy for 20 cycles, not reset by rst.
    always @(posedge clk) begin
        if (bus.startDump) reader_cnt <= 20;
        else if (reader_cnt > 0) reader_cnt <= reader_cnt - 1;
    end
    assign bus.dumpCompleted = (reader_cnt == 0);

    // Pulse monitor: values just before each edge are the settled cycle values.
    always @(posedge clk) begin
        if (bus.startDump) n_start++;
        if (bus.cmd_error) n_err++;
        if (bus.startDump && bus.cmd_error) n_both++;
    end

    typedef struct {
        string       name;
        logic [63:0] pkt;
        bit          accept;
        logic [23:0] sa;
        logic [23:0] ea;
    } vec_t;

    vec_t vecs [7];

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_addr(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_Data  = b;
        bus.in_Valid = 1'b1;
        @(negedge clk);
        bus.in_Valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [63:0] p, input int gap);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) repeat (gap) @(negedge clk);
            send_byte(p[63-8*i -: 8]);
        end
    endtask

    task automatic check_zero(input string name);
        check_addr({name, "_sa"}, bus.dumpStartAddress, 24'h0);
        check_addr({name, "_ea"}, bus.dumpEndAddress, 24'h0);
        check_bit({name, "_start"}, bus.startDump, 1'b0);
        check_bit({name, "_busy"}, bus.busy, 1'b0);
        check_bit({name, "_err"}, bus.cmd_error, 1'b0);
    endtask

    // Called two negedges after the CK byte, while the reader is still running.
    task automatic wait_idle(input string name);
        int n = 0;
        while (!bus.dumpCompleted && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.dumpCompleted) begin
            check_bit({name, "_reader_done"}, bus.dumpCompleted, 1'b1);
        end else begin
            check_bit({name, "_busy_at_rise"}, bus.busy, 1'b1);
            @(negedge clk);
            check_bit({name, "_busy_after_rise"}, bus.busy, 1'b0);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit wait_done, input int gap);
        int s0 = n_start;
        int e0 = n_err;
        send_pkt(v.pkt, gap);
        check_bit({v.name, "_no_early_pulse"}, bus.startDump | bus.cmd_error, 1'b0);
        @(negedge clk);
        if (v.accept) begin
            exp_sa = v.sa;
            exp_ea = v.ea;
        end
        check_bit({v.name, "_start"}, bus.startDump, v.accept);
        check_bit({v.name, "_err"}, bus.cmd_error, !v.accept);
        check_bit({v.name, "_busy"}, bus.busy, v.accept);
        check_addr({v.name, "_sa"}, bus.dumpStartAddress, exp_sa);
        check_addr({v.name, "_ea"}, bus.dumpEndAddress, exp_ea);
        @(negedge clk);
        check_int({v.name, "_start_pulses"}, n_start - s0, v.accept ? 1 : 0);
        check_int({v.name, "_err_pulses"}, n_err - e0, v.accept ? 0 : 1);
        if (v.accept && wait_done) wait_idle(v.name);
    endtask

    initial begin
        int s0;
        int e0;
        int k;

        vecs[0] = '{"valid_ff",     64'h44000000_0000FFFF, 1'b1, 24'h000000, 24'h0000FF};
        vecs[1] = '{"bad_ck",       64'h44123456_1234FF00, 1'b0, 24'h0,      24'h0};
        vecs[2] = '{"end_lt_start", 64'h44001000_000FFFE0, 1'b0, 24'h0,      24'h0};
        vecs[3] = '{"start_eq_end", 64'h44000005_00000500, 1'b1, 24'h000005, 24'h000005};
        vecs[4] = '{"valid_mid",    64'h44123456_1234FFA9, 1'b1, 24'h123456, 24'h1234FF};
        vecs[5] = '{"end_lt_by1",   64'h44000001_00000001, 1'b0, 24'h0,      24'h0};
        vecs[6] = '{"all_ff",       64'h44FFFFFF_FFFFFF00, 1'b1, 24'hFFFFFF, 24'hFFFFFF};

        bus.in_Data  = 8'h00;
        bus.in_Valid = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b1, 0);

        // Garbage before a command byte is ignored silently.
        s0 = n_start;
        e0 = n_err;
        send_byte(8'h00);
        send_byte(8'h55);
        send_byte(8'hAA);
        repeat (3) @(negedge clk);
        check_int("garbage_start", n_start - s0, 0);
        check_int("garbage_err", n_err - e0, 0);
        run_vec(vecs[0], 1'b1, 0);

        // Inter-byte timeout fires TMO cycles after the last byte.
        send_byte(8'h44);
        send_byte(8'h01);
        send_byte(8'h02);
        k = 0;
        while (!bus.cmd_error && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_int("timeout_latency", k, TMO);
        @(negedge clk);
        check_bit("timeout_err_one_cycle", bus.cmd_error, 1'b0);
        run_vec(vecs[3], 1'b1, 0);

        // A byte landing in the expiry cycle wins over the timeout.
        vecs[3].name = "byte_wins";
        run_vec(vecs[3], 1'b1, TMO - 1);

        // A full packet sent while busy is dropped.
        run_vec(vecs[4], 1'b0, 0);
        s0 = n_start;
        e0 = n_err;
        send_pkt(vecs[0].pkt, 0);
        check_int("busy_drop_start", n_start - s0, 0);
        check_int("busy_drop_err", n_err - e0, 0);
        check_bit("busy_drop_busy", bus.busy, 1'b1);
        check_addr("busy_drop_sa", bus.dumpStartAddress, 24'h123456);
        check_addr("busy_drop_ea", bus.dumpEndAddress, 24'h1234FF);
        wait_idle("busy_drop");

        // Asynchronous reset after the fourth byte of a packet.
        send_byte(8'h44);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        #2 rst = 1'b1;
        #1 check_zero("rst_mid_pkt");
        exp_sa = '0;
        exp_ea = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(vecs[4], 1'b1, 0);

        // Asynchronous reset while waiting for the reader to finish.
        run_vec(vecs[6], 1'b0, 0);
        repeat (3) @(negedge clk);
        check_bit("rst_wait_high_busy_pre", bus.busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("rst_wait_high");
        exp_sa = '0;
        exp_ea = '0;
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (!bus.dumpCompleted && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_bit("rst_reader_idle", bus.dumpCompleted, 1'b1);
        run_vec(vecs[4], 1'b1, 0);

        check_int("start_and_err_overlap", n_both, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
